mc14500_pc_seq: RTL and testbench

- Program-counter and fetch sequencer that drives the MC14500 ICU core from external byte-wide program ROM.
- Handles instruction fetch with a ROM wait-state handshake, JMP/CALL target loading from two extension bytes, RTN through a hardware return stack, and halt/resume.
- Sits between the ICU core and the PC/ROM pads inside the MC14500 project slot of the multiplexer.

---
 rtl/mc14500_pc_seq_if.sv | 17 +
 rtl/mc14500_pc_seq.sv | 153 +++++++++++++++
 tb/tb_mc14500_pc_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc14500_pc_seq_if.sv
// ROM bus between the MC14500 fetch sequencer and the program ROM pads.
//   pc_o     : ROM address (PC_W bits), driven by the sequencer
//   rom_req  : read request, held until rom_ack
//   rom_ack  : read data valid
//   rom_data : byte-wide ROM read data
// master = sequencer side, slave = ROM side.
interface mc14500_pc_seq_if #(
   parameter int PC_W = 16
);
   logic [PC_W-1:0] pc_o;
   logic            rom_req;
   logic            rom_ack;
   logic [7:0]      rom_data;

   modport master (output pc_o, rom_req, input rom_ack, rom_data);
   modport slave  (input pc_o, rom_req, output rom_ack, rom_data);
endinterface

// File: rtl/mc14500_pc_seq.sv
// Program-counter and fetch sequencer for the MC14500 ICU core.
// Fetches instruction bytes from a byte-wide ROM with a req/ack wait-state
// handshake, issues each byte to the ICU for one cycle, then reacts to the
// ICU flags: JMP/CALL load a target from the two following ROM bytes, RTN
// pops a hardware return stack, FLAG_F halts until resume_i.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rom                   : ROM bus (pc_o, rom_req, rom_ack, rom_data)
//   instr_o, instr_valid  : instruction byte and its one-cycle issue strobe
//   jmp_i, rtn_i          : ICU JMP / RTN flags, sampled in EXEC
//   flag_o_i, flag_f_i    : ICU FLAG_O (JMP+FLAG_O = CALL), FLAG_F (halt)
//   resume_i, halted      : leave HALT / HALT indicator
//   sp_o                  : return-stack occupancy
//   stk_ovf, stk_unf      : sticky stack overflow / underflow
module mc14500_pc_seq #(
   parameter int PC_W        = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   mc14500_pc_seq_if.master               rom,
   output logic [7:0]                     instr_o,
   output logic                           instr_valid,
   input  logic                           jmp_i,
   input  logic                           rtn_i,
   input  logic                           flag_o_i,
   input  logic                           flag_f_i,
   input  logic                           resume_i,
   output logic                           halted,
   output logic [$clog2(STACK_DEPTH):0]   sp_o,
   output logic                           stk_ovf,
   output logic                           stk_unf
);
   localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
   localparam int IDX_W = $clog2(STACK_DEPTH);

   // IDLE exists only so that rom_req stays low during reset; it always
   // moves to FETCH on the first edge after release.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_EXT0  = 3'd4;
   localparam logic [2:0] S_EXT1  = 3'd5;
   localparam logic [2:0] S_HALT  = 3'd6;

   logic [2:0]      state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_inc;
   logic [7:0]      instr;
   logic [7:0]      tgt_lo;
   logic [15:0]     tgt;
   logic            call;
   logic [SP_W-1:0] sp;
   logic [SP_W-1:0] sp_dec;
   logic            full;
   logic            push;
   logic [IDX_W-1:0] push_idx;
   logic            ovf;
   logic            unf;
   logic [PC_W-1:0] stack [STACK_DEPTH];

   assign pc_inc   = pc + PC_W'(1);
   assign tgt      = {rom.rom_data, tgt_lo};
   assign sp_dec   = sp - SP_W'(1);
   assign full     = (sp == SP_W'(STACK_DEPTH));
   assign push     = (state == S_EXT1) && rom.rom_ack && call;
   // A push onto a full stack replaces the top entry instead of growing.
   assign push_idx = full ? IDX_W'(STACK_DEPTH - 1) : sp[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         pc     <= '0;
         instr  <= '0;
         tgt_lo <= '0;
         call   <= 1'b0;
         sp     <= '0;
         ovf    <= 1'b0;
         unf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE:  state <= S_FETCH;
            S_FETCH: begin
               if (rom.rom_ack) begin
                  instr <= rom.rom_data;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_EXEC;
            S_EXEC: begin
               call <= flag_o_i;
               if (flag_f_i) begin
                  pc    <= pc_inc;
                  state <= S_HALT;
               end else if (jmp_i) begin
                  // JMP and RTN together is a malformed request: jump wins.
                  if (rtn_i) unf <= 1'b1;
                  pc    <= pc_inc;
                  state <= S_EXT0;
               end else if (rtn_i) begin
                  if (sp == '0) begin
                     pc  <= '0;
                     unf <= 1'b1;
                  end else begin
                     pc <= stack[sp_dec[IDX_W-1:0]];
                     sp <= sp_dec;
                  end
                  state <= S_FETCH;
               end else begin
                  pc    <= pc_inc;
                  state <= S_FETCH;
               end
            end
            S_EXT0: begin
               if (rom.rom_ack) begin
                  tgt_lo <= rom.rom_data;
                  pc     <= pc_inc;
                  state  <= S_EXT1;
               end
            end
            S_EXT1: begin
               if (rom.rom_ack) begin
                  if (call) begin
                     if (full) ovf <= 1'b1;
                     else      sp  <= sp + SP_W'(1);
                  end
                  pc    <= tgt[PC_W-1:0];
                  state <= S_FETCH;
               end
            end
            S_HALT: begin
               if (resume_i) state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Return address is the byte after the second extension byte.
   always_ff @(posedge clk) begin
      if (push) stack[push_idx] <= pc_inc;
   end

   assign rom.pc_o    = pc;
   assign rom.rom_req = (state == S_FETCH) || (state == S_EXT0) || (state == S_EXT1);
   assign instr_o     = instr;
   assign instr_valid = (state == S_ISSUE);
   assign halted      = (state == S_HALT);
   assign sp_o        = sp;
   assign stk_ovf     = ovf;
   assign stk_unf     = unf;
endmodule

// File: tb/tb_mc14500_pc_seq.sv
// Self-checking bench for mc14500_pc_seq (PC_W=12, STACK_DEPTH=4).
// A ROM responder with configurable wait states and an ICU stand-in that
// decodes the issued byte into flags drive the DUT; an instruction-level
// model (PC, return-stack queue, sticky flags) predicts every issued
// address/byte and the cycle distance between issues.
// ICU stand-in opcodes: C=JMP, E=CALL, D=RTN, B=JMP+RTN, F=FLAG_F
// (with bit0/bit1 also raising JMP/RTN), everything else plain.
module tb_mc14500_pc_seq;
   localparam int PC_W  = 12;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mc14500_pc_seq_if #(.PC_W(PC_W)) rom_if ();

   logic [7:0] instr_o;
   logic       instr_valid;
   logic       jmp_i = 1'b0, rtn_i = 1'b0, flag_o_i = 1'b0, flag_f_i = 1'b0;
   logic       resume_i = 1'b0;
   logic       halted, stk_ovf, stk_unf;
   logic [2:0] sp_o;

   mc14500_pc_seq #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .rom(rom_if),
      .instr_o(instr_o), .instr_valid(instr_valid),
      .jmp_i(jmp_i), .rtn_i(rtn_i), .flag_o_i(flag_o_i), .flag_f_i(flag_f_i),
      .resume_i(resume_i), .halted(halted), .sp_o(sp_o),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]      mem [1 << PC_W];
   logic [PC_W-1:0] mpc;
   logic [PC_W-1:0] stk [$];
   logic            movf, munf;
   bit              have_prev, prev_halt, prev_halted, prev_resume, pending, resume_en;
   int              prev_extra, cnt, waits, hcnt, n_issued, wfix, wcnt;
   logic [PC_W-1:0] req_pc;

   task automatic model_reset();
      mpc = '0; stk.delete(); movf = 1'b0; munf = 1'b0;
      have_prev = 0; prev_halt = 0; prev_extra = 0;
      cnt = 0; waits = 0; hcnt = 0;
   endtask

   task automatic model_step(input logic [7:0] b);
      logic [15:0] t;
      t = {mem[mpc + PC_W'(2)], mem[mpc + PC_W'(1)]};
      prev_extra = 0;
      prev_halt  = 0;
      case (b[7:4])
         4'hF: begin prev_halt = 1; mpc = mpc + PC_W'(1); end
         4'hB, 4'hC, 4'hE: begin
            if (b[7:4] == 4'hE) begin
               if (stk.size() == DEPTH) begin
                  stk[DEPTH-1] = mpc + PC_W'(3);
                  movf = 1'b1;
               end else stk.push_back(mpc + PC_W'(3));
            end
            if (b[7:4] == 4'hB) munf = 1'b1;
            mpc = t[PC_W-1:0];
            prev_extra = 2;
         end
         4'hD: begin
            if (stk.size() == 0) begin mpc = '0; munf = 1'b1; end
            else mpc = stk.pop_back();
         end
         default: mpc = mpc + PC_W'(1);
      endcase
   endtask

   // ---------------- monitor + ROM responder + ICU stand-in ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            cnt++;
            if (prev_halted) chk("halt_exit", 32'(halted), 32'(!prev_resume));
            if (halted) begin
               chk("halt_req", 32'(rom_if.rom_req), 32'd0);
               hcnt++;
            end
            if (instr_valid) begin
               chk("pc", 32'(rom_if.pc_o), 32'(mpc));
               chk("instr", 32'(instr_o), 32'(mem[mpc]));
               chk("sp", 32'(sp_o), 32'(stk.size()));
               chk("ovf", 32'(stk_ovf), 32'(movf));
               chk("unf", 32'(stk_unf), 32'(munf));
               if (have_prev) begin
                  chk("period", 32'(cnt), 32'(3 + prev_extra + waits + hcnt));
                  chk("halt_seen", 32'(hcnt != 0), 32'(prev_halt));
               end
               model_step(mem[mpc]);
               have_prev = 1; cnt = 0; waits = 0; hcnt = 0;
               n_issued++;
            end
         end
         // ROM: wcnt wait cycles per request, junk ack/data outside requests
         if (rst_n && rom_if.rom_req) begin
            if (!pending) begin
               pending = 1;
               req_pc  = rom_if.pc_o;
               wcnt    = (wfix >= 0) ? wfix : int'($urandom_range(3));
            end else chk("pc_stable", 32'(rom_if.pc_o), 32'(req_pc));
            if (wcnt == 0) begin
               rom_if.rom_ack  = 1'b1;
               rom_if.rom_data = mem[req_pc];
               pending = 0;
            end else begin
               rom_if.rom_ack  = 1'b0;
               rom_if.rom_data = 8'($urandom);
               wcnt--;
               waits++;
            end
         end else begin
            pending = 0;
            rom_if.rom_ack  = 1'($urandom);
            rom_if.rom_data = 8'($urandom);
         end
         jmp_i    = (instr_o[7:4] inside {4'hB, 4'hC, 4'hE}) || (instr_o[7:4] == 4'hF && instr_o[0]);
         rtn_i    = (instr_o[7:4] inside {4'hB, 4'hD}) || (instr_o[7:4] == 4'hF && instr_o[1]);
         flag_o_i = (instr_o[7:4] == 4'hE) || (instr_o[7:4] == 4'hD && instr_o[0]);
         flag_f_i = (instr_o[7:4] == 4'hF);
         resume_i = resume_en && ($urandom_range(3) == 0);
         prev_halted = rst_n && halted;
         prev_resume = resume_i;
      end
   end

   // ---------------- stimulus ----------------
   task automatic fill_plain();
      for (int i = 0; i < (1 << PC_W); i++) mem[i] = {4'($urandom_range(10)), 4'($urandom_range(15))};
   endtask

   task automatic fill_random();
      for (int i = 0; i < (1 << PC_W); i++) mem[i] = 8'($urandom);
   endtask

   task automatic hold_reset();
      @(posedge clk); #2 rst_n = 1'b0;
      model_reset();
   endtask

   task automatic release_reset();
      @(negedge clk); @(posedge clk); #2 rst_n = 1'b1;
   endtask

   task automatic run_phase(input int n);
      int tgt;
      tgt = n_issued + n;
      for (int c = 0; c < n * 60 + 200 && n_issued < tgt; c++) @(negedge clk);
      chk("progress", 32'(n_issued >= tgt), 32'd1);
   endtask

   initial begin
      rom_if.rom_ack = 1'b0; rom_if.rom_data = '0;
      resume_en = 1; wfix = 0; n_issued = 0;
      model_reset();
      fill_plain();
      repeat (3) @(negedge clk);
      chk("rst_pc", 32'(rom_if.pc_o), 32'd0);
      chk("rst_req", 32'(rom_if.rom_req), 32'd0);
      chk("rst_instr", 32'(instr_o), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_halt", 32'(halted), 32'd0);
      chk("rst_sp", 32'(sp_o), 32'd0);
      chk("rst_ovf", 32'(stk_ovf), 32'd0);
      chk("rst_unf", 32'(stk_unf), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      run_phase(12);                       // linear, zero-wait

      hold_reset(); wfix = 2; release_reset();
      run_phase(10);                       // two wait states per read

      hold_reset(); wfix = 0; fill_plain();
      mem[12'h010] = 8'hC5; mem[12'h011] = 8'h34; mem[12'h012] = 8'h12;
      release_reset();
      run_phase(20);                       // JMP 0x1234 -> 0x234

      hold_reset(); fill_plain();
      mem[12'h020] = 8'hE0; mem[12'h021] = 8'h00; mem[12'h022] = 8'h01;
      mem[12'h100] = 8'hD0;
      release_reset();
      run_phase(40);                       // CALL 0x100, RTN to 0x023

      hold_reset(); fill_plain();
      for (int k = 0; k < 5; k++) begin
         mem[k * 256]     = 8'hE0;
         mem[k * 256 + 1] = 8'h00;
         mem[k * 256 + 2] = 8'(k + 1);
      end
      mem[12'h500] = 8'hD0; mem[12'h403] = 8'hD0; mem[12'h203] = 8'hD0;
      mem[12'h103] = 8'hD0; mem[12'h003] = 8'hD0;
      release_reset();
      run_phase(14);                       // 5 nested calls, 5 returns

      hold_reset(); fill_plain(); mem[12'h005] = 8'hF0; resume_en = 0;
      release_reset();
      for (int c = 0; c < 100 && !halted; c++) @(negedge clk);
      chk("halt_reached", 32'(halted), 32'd1);
      repeat (20) @(negedge clk);
      chk("halt_hold", 32'(halted), 32'd1);
      resume_en = 1;
      run_phase(4);                        // resumes at 0x006

      hold_reset(); fill_plain();
      mem[12'h000] = 8'hC0; mem[12'h001] = 8'hFD; mem[12'h002] = 8'h0F;
      mem[12'hFFE] = 8'hC0; mem[12'hFFF] = 8'h34;
      release_reset();
      run_phase(10);                       // extension fetch wraps FFF->000

      hold_reset(); fill_plain(); wfix = 5;
      release_reset();
      run_phase(2);
      for (int c = 0; c < 50 && !rom_if.rom_req; c++) @(negedge clk);
      @(negedge clk);
      chk("req_waiting", 32'(rom_if.rom_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(rom_if.rom_req), 32'd0);
      chk("arst_pc", 32'(rom_if.pc_o), 32'd0);
      chk("arst_valid", 32'(instr_valid), 32'd0);
      model_reset(); wfix = 1;
      release_reset();
      run_phase(5);                        // first fetch at 0 again

      hold_reset(); fill_random(); wfix = -1; resume_en = 1;
      release_reset();
      run_phase(400);                      // random program, random waits

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
